cordic_log_sched: RTL and testbench

//  Front-end scheduler for the 19-cycle hyperbolic CORDIC log pipeline (ln(a) = 2*atanh((a-1)/(a+1))).
//  Two requesters share the datapath through round-robin arbitration; the block pre-conditions x/y for
//  the datapath, tracks in-flight tags alongside the datapath (which has no valid/stall), and buffers

---
 rtl/cordic_log_pkg.sv | 21 ++
 rtl/cordic_res_fifo.sv | 64 ++++++
 rtl/cordic_log_sched.sv | 121 ++++++++++++
 tb/tb_cordic_log_sched.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_log_pkg.sv
// rtl/cordic_log_pkg.sv - shared constants and types for the CORDIC log scheduler
package cordic_log_pkg;

  localparam int          FRAC      = 24;
  localparam logic [31:0] ONE       = 32'h1 << FRAC;
  localparam int          PIPE_LAT  = 19;
  localparam logic [31:0] ERR_VALUE = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] data;
    logic        id;
    logic        err;
  } res_entry_t;

  typedef struct packed {
    logic valid;
    logic id;
    logic err;
  } tag_t;

endpackage

// File: rtl/cordic_res_fifo.sv
// rtl/cordic_res_fifo.sv - show-ahead result FIFO with occupancy count
module cordic_res_fifo
  import cordic_log_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  res_entry_t    push_data_i,
  input  logic          pop_i,
  output res_entry_t    head_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  res_entry_t    mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // The scheduler's credit scheme guarantees room, so a push is never refused.
  assign do_pop = pop_i && (cnt_q != '0);

  always_comb begin
    wr_d  = push_i ? bump(wr_q) : wr_q;
    rd_d  = do_pop ? bump(rd_q) : rd_q;
    cnt_d = cnt_q;
    case ({push_i, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= push_data_i;
  end

  // Head reads as zero when empty so the outputs show their reset values.
  assign empty_o = (cnt_q == '0);
  assign head_o  = empty_o ? '0 : mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/cordic_log_sched.sv
// rtl/cordic_log_sched.sv - two-requester front end for the 19-cycle CORDIC log pipeline
module cordic_log_sched #(
  parameter int FRAC       = cordic_log_pkg::FRAC,
  parameter int PIPE_LAT   = cordic_log_pkg::PIPE_LAT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req1_a,
  output logic [1:0]  req_ready,
  output logic [31:0] cx,
  output logic [31:0] cy,
  input  logic [31:0] cz,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic        res_id,
  output logic        res_err,
  input  logic        res_ready
);

  import cordic_log_pkg::*;

  localparam int          CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] ONE_V   = 32'h1 << FRAC;
  localparam logic [CW:0] DEPTH_V = (CW + 1)'(FIFO_DEPTH);

  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] fifo_cnt;
  logic [CW:0]   outstanding;
  logic          ptr_q, ptr_d;
  logic          run_q;
  logic          credit_ok;
  logic          grant;
  logic          hs;
  logic [31:0]   g_a;
  logic          g_err;
  tag_t          tag_q [PIPE_LAT];
  tag_t          tail;
  logic          push;
  res_entry_t    push_entry;
  res_entry_t    head;
  logic          fifo_empty;
  logic          pop;

  // run_q keeps req_ready low until the first edge after reset release.
  assign outstanding = {1'b0, inflight_q} + {1'b0, fifo_cnt};
  assign credit_ok   = run_q && (outstanding < DEPTH_V);

  always_comb begin
    grant = ptr_q;
    if (req_valid == 2'b01)      grant = 1'b0;
    else if (req_valid == 2'b10) grant = 1'b1;
    req_ready = {credit_ok & grant, credit_ok & ~grant};
    hs        = |(req_valid & req_ready);
    g_a       = grant ? req1_a : req0_a;
    g_err     = ($signed(g_a) <= 0);
    ptr_d     = hs ? ~grant : ptr_q;
    cx        = ONE_V;
    cy        = '0;
    if (hs) begin
      cx = g_a + ONE_V;
      cy = g_a - ONE_V;
    end
  end

  assign tail       = tag_q[PIPE_LAT-1];
  assign push       = tail.valid;
  assign push_entry = '{data: tail.err ? ERR_VALUE : cz, id: tail.id, err: tail.err};

  always_comb begin
    inflight_d = inflight_q;
    case ({hs, push})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= '0;
      ptr_q      <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      ptr_q      <= ptr_d;
      run_q      <= 1'b1;
    end
  end

  // Tags travel beside the datapath, which has no valid of its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= hs ? '{valid: 1'b1, id: grant, err: g_err} : '0;
      for (int i = 1; i < PIPE_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign pop = res_valid && res_ready;

  cordic_res_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .empty_o     (fifo_empty),
    .count_o     (fifo_cnt)
  );

  assign res_valid = !fifo_empty;
  assign res_data  = head.data;
  assign res_id    = head.id;
  assign res_err   = head.err;

endmodule

// File: tb/tb_cordic_log_sched.sv
// tb/tb_cordic_log_sched.sv - scoreboard bench for cordic_log_sched with a behavioural datapath
module tb_cordic_log_sched;
  import cordic_log_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [31:0] req0_a, req1_a;
  logic [1:0]  req_ready;
  logic [31:0] cx, cy, cz;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_id, res_err;
  logic        res_ready;

  cordic_log_sched #(.FRAC(24), .PIPE_LAT(19), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req0_a    (req0_a),
    .req1_a    (req1_a),
    .req_ready (req_ready),
    .cx        (cx),
    .cy        (cy),
    .cz        (cz),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_err   (res_err),
    .res_ready (res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] lnf(input logic [31:0] a);
    real r;
    if ($signed(a) <= 0) return 32'hDEAD_BEEF;
    r = $ln(real'($signed(a)) / 16777216.0) * 16777216.0;
    return 32'($rtoi(r));
  endfunction

  // Datapath stand-in: 19 unreset stages from x/y sampling to z.
  logic [31:0] dp [19];
  always @(posedge clk) begin
    dp[0] <= lnf(cx - ONE);
    for (int i = 1; i < 19; i++) dp[i] <= dp[i-1];
  end
  assign cz = dp[18];

  int          n_chk = 0;
  int          n_fail = 0;
  res_entry_t  exp_q[$];
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          cyc = 0;
  int          hs_cyc = -1;
  int          seen_cyc = -1;
  int          n_hs = 0;
  int          outst = 0;
  logic        armed = 1'b0;
  logic        last_gid = 1'b1;
  logic        hold = 1'b0;
  res_entry_t  hold_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic cycle();
    res_entry_t  e;
    logic [31:0] a;
    logic        gid;
    logic        hs;
    req_valid = {q1.size() != 0, q0.size() != 0};
    req0_a    = (q0.size() != 0) ? q0[0] : 32'h0;
    req1_a    = (q1.size() != 0) ? q1[0] : 32'h0;
    #1;
    if (hold) begin
      check("hold_data", res_data, hold_e.data);
      check("hold_id", {31'b0, res_id}, {31'b0, hold_e.id});
      check("hold_valid", {31'b0, res_valid}, 32'd1);
    end
    check("credit", {31'b0, |req_ready}, {31'b0, armed && (outst < 4)});
    if (res_valid && seen_cyc < 0) seen_cyc = cyc;
    hold   = res_valid && !res_ready;
    hold_e = '{data: res_data, id: res_id, err: res_err};
    if (res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_res", {31'b0, res_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("res_data", res_data, e.data);
        check("res_id", {31'b0, res_id}, {31'b0, e.id});
        check("res_err", {31'b0, res_err}, {31'b0, e.err});
      end
      outst--;
    end
    hs  = 1'b0;
    gid = 1'b0;
    if (req_valid[0] && req_ready[0]) begin hs = 1'b1; gid = 1'b0; end
    else if (req_valid[1] && req_ready[1]) begin hs = 1'b1; gid = 1'b1; end
    if (hs) begin
      if (req_valid == 2'b11) check("rr_alt", {31'b0, gid}, {31'b0, ~last_gid});
      a = gid ? req1_a : req0_a;
      check("cx_issue", cx, a + ONE);
      check("cy_issue", cy, a - ONE);
      e.err  = ($signed(a) <= 0);
      e.data = e.err ? ERR_VALUE : lnf(a);
      e.id   = gid;
      exp_q.push_back(e);
      if (gid) void'(q1.pop_front()); else void'(q0.pop_front());
      last_gid = gid;
      hs_cyc   = cyc;
      n_hs++;
      outst++;
    end else begin
      check("cx_bubble", cx, ONE);
      check("cy_bubble", cy, 32'h0);
    end
    @(posedge clk);
    armed = rst_n;
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (q0.size() + q1.size() + exp_q.size() != 0); i++) cycle();
    check("drain_left", 32'(q0.size() + q1.size() + exp_q.size()), 32'd0);
  endtask

  initial begin
    int t;
    int h0;
    rst_n     = 1'b0;
    req_valid = 2'b00;
    req0_a    = '0;
    req1_a    = '0;
    res_ready = 1'b0;
    #2;
    check("rst_req_ready", {30'b0, req_ready}, 32'd0);
    check("rst_res_valid", {31'b0, res_valid}, 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_res_id", {31'b0, res_id}, 32'd0);
    check("rst_res_err", {31'b0, res_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single request with a = 1.0: latency and ln(1) = 0.
    res_ready = 1'b1;
    cycle();
    seen_cyc = -1;
    q0.push_back(ONE);
    cycle();
    for (int i = 0; i < 40 && seen_cyc < 0; i++) cycle();
    check("latency", 32'(seen_cyc - hs_cyc - 1), 32'd19);
    drain();

    // Both requesters busy: alternating grants, ids in order.
    for (int i = 0; i < 8; i++) begin
      q0.push_back(ONE * (i + 2));
      q1.push_back(32'h0040_0000 + 32'($urandom_range(0, 32'h00FF_FFFF)));
    end
    drain();

    // Backpressure: exactly FIFO_DEPTH handshakes, then resume after the first pop.
    res_ready = 1'b0;
    n_hs = 0;
    for (int i = 0; i < 6; i++) q0.push_back(ONE + 32'(i) * 32'h0010_0000);
    repeat (30) cycle();
    check("full_handshakes", 32'(n_hs), 32'd4);
    res_ready = 1'b1;
    drain();

    // Non-positive operands interleaved with valid ones.
    q0.push_back(ONE * 2);
    q0.push_back(32'h0);
    q0.push_back(32'hFFFF_FFFF);
    q1.push_back(32'h0080_0000);
    q1.push_back(32'h8000_0000);
    q1.push_back(ONE * 5);
    drain();

    // Simultaneous push and pop with three entries buffered, then with one.
    res_ready = 1'b0;
    q0.push_back(ONE * 3);
    q0.push_back(ONE * 4);
    q0.push_back(ONE * 6);
    repeat (5) cycle();
    h0 = n_hs;
    q0.push_back(ONE * 7);
    cycle();
    check("hs_d", 32'(n_hs), 32'(h0 + 1));
    t = hs_cyc;
    while (cyc < t + 19) cycle();
    res_ready = 1'b1;
    cycle();
    check("pop_push_at3", 32'(exp_q.size()), 32'd3);
    cycle();
    cycle();
    res_ready = 1'b0;
    h0 = n_hs;
    q1.push_back(ONE * 8);
    cycle();
    check("hs_e", 32'(n_hs), 32'(h0 + 1));
    t = hs_cyc;
    while (cyc < t + 19) cycle();
    res_ready = 1'b1;
    cycle();
    check("pop_push_at1", 32'(exp_q.size()), 32'd1);
    check("still_valid", {31'b0, res_valid}, 32'd1);
    drain();

    // Reset with results both in flight and buffered.
    res_ready = 1'b0;
    q0.push_back(ONE * 2);
    q0.push_back(ONE * 3);
    repeat (25) cycle();
    q1.push_back(ONE * 4);
    q1.push_back(ONE * 5);
    repeat (5) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_res_valid", {31'b0, res_valid}, 32'd0);
    check("mid_rst_res_data", res_data, 32'd0);
    check("mid_rst_res_id", {31'b0, res_id}, 32'd0);
    check("mid_rst_res_err", {31'b0, res_err}, 32'd0);
    check("mid_rst_req_ready", {30'b0, req_ready}, 32'd0);
    exp_q.delete();
    q0.delete();
    q1.delete();
    outst    = 0;
    hold     = 1'b0;
    armed    = 1'b0;
    last_gid = 1'b1;
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    res_ready = 1'b1;
    repeat (30) cycle();
    q0.push_back(ONE * 9);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
